// File: rtl/ram_loader.sv
`default_nettype none
// ============================================================================
// Module      : ram_loader
// Description : Streams a checksummed block of words into RAM. The upstream
//               source presents len payload words followed by a single
//               checksum word.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_loader #(
    parameter int ADDR_WIDTH = 5,
    parameter int WORD_SIZE  = 8,
    parameter int RAM_DEPTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   len,
    input  logic                  in_valid,
    input  logic [WORD_SIZE-1:0]  in_data,
    output logic                  in_ready,
    output logic                  ram_write_en,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [WORD_SIZE-1:0]  ram_write_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_load  = 2'd1;
    localparam logic [1:0] c_check = 2'd2;
    localparam logic [1:0] c_fin   = 2'd3;

    localparam logic [ADDR_WIDTH:0]   c_depth    = (ADDR_WIDTH+1)'(RAM_DEPTH);
    localparam logic [ADDR_WIDTH:0]   c_len_one  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] c_last     = ADDR_WIDTH'(RAM_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] c_addr_one = ADDR_WIDTH'(1);

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH:0]   r_remaining;
    logic [WORD_SIZE-1:0]  r_sum;
    logic                  r_err;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [WORD_SIZE-1:0]  r_wdata;

    logic                  w_in_ready;
    logic                  w_xfer;
    logic [ADDR_WIDTH:0]   w_eff_len;
    logic [ADDR_WIDTH-1:0] w_next_ptr;

    assign w_in_ready = (r_state == c_load) || (r_state == c_check);
    assign w_xfer     = in_valid && w_in_ready;
    // Requests longer than the RAM are clipped so the pointer never laps itself
    assign w_eff_len  = (len > c_depth) ? c_depth : len;
    assign w_next_ptr = (r_ptr == c_last) ? '0 : r_ptr + c_addr_one;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_idle;
            r_ptr       <= '0;
            r_remaining <= '0;
            r_sum       <= '0;
            r_err       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (start) begin
                        r_ptr       <= base_addr;
                        r_remaining <= w_eff_len;
                        r_sum       <= '0;
                        r_err       <= 1'b0;
                        r_state     <= (w_eff_len != '0) ? c_load : c_check;
                    end
                end
                c_load: begin
                    if (w_xfer) begin
                        r_we        <= 1'b1;
                        r_addr      <= r_ptr;
                        r_wdata     <= in_data;
                        r_sum       <= r_sum + in_data;
                        r_ptr       <= w_next_ptr;
                        r_remaining <= r_remaining - c_len_one;
                        if (r_remaining == c_len_one) begin
                            r_state <= c_check;
                        end
                    end
                end
                c_check: begin
                    if (w_xfer) begin
                        r_err   <= (in_data != r_sum);
                        r_state <= c_fin;
                    end
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    assign in_ready       = w_in_ready;
    assign ram_write_en   = r_we;
    assign ram_address    = r_addr;
    assign ram_write_data = r_wdata;
    assign busy           = (r_state != c_idle);
    assign done           = (r_state == c_fin);
    assign err            = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ram_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_loader
// Description : Randomised scoreboard bench for ram_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_loader;

    localparam int AW    = 5;
    localparam int WS    = 8;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len;
    logic          in_valid;
    logic [WS-1:0] in_data;
    logic          in_ready;
    logic          ram_write_en;
    logic [AW-1:0] ram_address;
    logic [WS-1:0] ram_write_data;
    logic          busy;
    logic          done;
    logic          err;

    ram_loader #(.ADDR_WIDTH(AW), .WORD_SIZE(WS), .RAM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .ram_write_en(ram_write_en), .ram_address(ram_address),
        .ram_write_data(ram_write_data), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    typedef struct {
        int err;
        int cyc;
    } dn_t;

    wr_t exp_w[$];
    dn_t exp_d[$];
    wr_t mon_w;
    dn_t mon_d;
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    int  pay[$];
    int  ck;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every write and every done pulse must match the head of its queue
    always @(negedge clk) begin
        if (ram_write_en) begin
            if (exp_w.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_write: got addr %0d data %0d expected none (cycle %0d)",
                         ram_address, ram_write_data, cyc);
            end else begin
                mon_w = exp_w.pop_front();
                chk("wr_addr", int'(ram_address), mon_w.addr);
                chk("wr_data", int'(ram_write_data), mon_w.data);
                chk("wr_cycle", cyc, mon_w.cyc);
            end
        end else if (exp_w.size() > 0 && exp_w[0].cyc <= cyc) begin
            mon_w = exp_w.pop_front();
            checks++; errors++;
            $display("FAIL missing_write: got none expected addr %0d data %0d at cycle %0d",
                     mon_w.addr, mon_w.data, mon_w.cyc);
        end
        if (done) begin
            if (exp_d.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                mon_d = exp_d.pop_front();
                chk("done_err", int'(err), mon_d.err);
                chk("done_cycle", cyc, mon_d.cyc);
            end
        end else if (exp_d.size() > 0 && exp_d[0].cyc <= cyc) begin
            mon_d = exp_d.pop_front();
            checks++; errors++;
            $display("FAIL missing_done: got 0 expected 1 at cycle %0d", mon_d.cyc);
        end
    end

    task automatic fill_rand(input int n, input bit good);
        int s = 0;
        pay.delete();
        for (int i = 0; i < n; i++) begin
            pay.push_back(int'($urandom_range(255)));
            s = (s + pay[i]) % 256;
        end
        ck = good ? s : int'($urandom_range(255));
    endtask

    // Idle cycles on the stream; stray start pulses here must be ignored
    task automatic gap(input int pct);
        while (int'($urandom_range(99)) < pct) begin
            in_valid = 1'b0;
            if ($urandom_range(3) == 0) begin
                start     = 1'b1;
                base_addr = AW'($urandom);
                len       = (AW+1)'($urandom);
            end
            chk("busy_gap", int'(busy), 1);
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    // One load; rst_after >= 0 aborts with reset in place of that payload word
    task automatic do_load(input int base, input int ln, input int gap_pct, input int rst_after);
        int l = (ln > DEPTH) ? DEPTH : ln;
        int s = 0;
        int e;
        for (int i = 0; i < l; i++) s = (s + pay[i]) % 256;
        e = (ck != s) ? 1 : 0;
        chk("idle_in_ready", int'(in_ready), 0);
        chk("idle_busy", int'(busy), 0);
        start     = 1'b1;
        base_addr = AW'(base);
        len       = (AW+1)'(ln);
        @(negedge clk);
        start     = 1'b0;
        base_addr = AW'($urandom);
        len       = (AW+1)'($urandom);
        chk("start_busy", int'(busy), 1);
        chk("start_err_clear", int'(err), 0);
        for (int i = 0; i < l; i++) begin
            gap(gap_pct);
            if (i == rst_after) begin
                rst      = 1'b1;
                in_valid = 1'b1;
                in_data  = WS'($urandom);
                @(negedge clk);
                rst      = 1'b0;
                in_valid = 1'b0;
                chk("rst_busy", int'(busy), 0);
                chk("rst_we", int'(ram_write_en), 0);
                chk("rst_addr", int'(ram_address), 0);
                chk("rst_err", int'(err), 0);
                chk("rst_in_ready", int'(in_ready), 0);
                return;
            end
            in_valid = 1'b1;
            in_data  = WS'(pay[i]);
            chk("load_in_ready", int'(in_ready), 1);
            exp_w.push_back('{addr: (base + i) % DEPTH, data: pay[i], cyc: cyc + 1});
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = WS'($urandom);
        end
        gap(gap_pct);
        in_valid = 1'b1;
        in_data  = WS'(ck);
        chk("check_in_ready", int'(in_ready), 1);
        exp_d.push_back('{err: e, cyc: cyc + 1});
        @(negedge clk);
        in_valid = 1'b0;
        chk("fin_busy", int'(busy), 1);
        chk("fin_in_ready", int'(in_ready), 0);
        @(negedge clk);
        chk("post_busy", int'(busy), 0);
        chk("post_err", int'(err), e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; in_valid = 1'b0; in_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_we0", int'(ram_write_en), 0);
        chk("rst_addr0", int'(ram_address), 0);
        chk("rst_data0", int'(ram_write_data), 0);
        chk("rst_busy0", int'(busy), 0);
        chk("rst_done0", int'(done), 0);
        chk("rst_err0", int'(err), 0);
        chk("rst_in_ready0", int'(in_ready), 0);
        rst = 1'b0;
        @(negedge clk);

        pay = '{8'h01, 8'h02, 8'h03, 8'h04}; ck = 8'h0A;
        do_load(0, 4, 0, -1);
        pay = '{8'hAA, 8'hBB, 8'hCC, 8'hDD}; ck = 8'h0E;
        do_load(30, 4, 0, -1);
        pay = '{8'hFF, 8'h02}; ck = 8'h00;
        do_load(5, 2, 0, -1);
        repeat (3) @(negedge clk);
        chk("err_held", int'(err), 1);
        pay.delete(); ck = 8'h00;
        do_load(7, 0, 0, -1);
        fill_rand(32, 1'b1);
        do_load(3, 40, 0, -1);
        fill_rand(8, 1'b1);
        do_load(28, 8, 50, -1);
        fill_rand(4, 1'b1);
        do_load(12, 4, 0, 2);
        fill_rand(3, 1'b1);
        do_load(10, 3, 0, -1);

        for (int n = 0; n < 40; n++) begin
            int b  = int'($urandom_range(DEPTH - 1));
            int ln = int'($urandom_range(40));
            int l  = (ln > DEPTH) ? DEPTH : ln;
            int ra = -1;
            if (l > 0 && $urandom_range(9) == 0) ra = int'($urandom_range(l - 1));
            fill_rand(l, $urandom_range(9) < 7);
            do_load(b, ln, int'($urandom_range(40)), ra);
            repeat ($urandom_range(2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("pending_writes", exp_w.size(), 0);
        chk("pending_done", exp_d.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram_loader.md
RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default `ADDR_WIDTH (5), RAM address width.
REQ-002 SHALL have parameter WORD_SIZE, default `WORD_SIZE (8), data word width.
REQ-003 SHALL have parameter RAM_DEPTH, default `RAM_DEPTH (32), number of RAM words.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, one-cycle request to begin a load.
REQ-007 SHALL have port base_addr, input, ADDR_WIDTH, first RAM address written; sampled with start.
REQ-008 SHALL have port len, input, ADDR_WIDTH+1, number of payload words; sampled with start.
REQ-009 SHALL have port in_valid, input, 1, upstream byte-source word valid.
REQ-010 SHALL have port in_data, input, WORD_SIZE, upstream payload or checksum word.
REQ-011 SHALL have port in_ready, output, 1, loader accepts in_data this cycle.
REQ-012 SHALL have port ram_write_en, output, 1, drives RAM write_en.
REQ-013 SHALL have port ram_address, output, ADDR_WIDTH, drives RAM address.
REQ-014 SHALL have port ram_write_data, output, WORD_SIZE, drives RAM write_data.
REQ-015 SHALL have port busy, output, 1, load in progress; also serves as CPU hold.
REQ-016 SHALL have port done, output, 1, one-cycle pulse at end of load.
REQ-017 SHALL have port err, output, 1, checksum mismatch flag.

Function
REQ-018 SHALL implement states IDLE, LOAD, CHECK, FIN.
REQ-019 IDLE: start=1 -> capture base_addr, effective length L=min(len,RAM_DEPTH), clear sum and err; go LOAD if L>0, else CHECK.
REQ-020 start SHALL be ignored in every state other than IDLE.
REQ-021 in_ready SHALL be 1 exactly in LOAD and CHECK, 0 in IDLE and FIN; busy SHALL be 1 in LOAD, CHECK, FIN.
REQ-022 Transfer occurs on an edge where in_valid=1 and in_ready=1; in_valid=0 stalls indefinitely with no side effects.
REQ-023 LOAD transfer: ram_write_en, ram_address (current pointer), ram_write_data (in_data) SHALL be registered and valid for exactly the following cycle, so RAM writes at the next edge (latency 1).
REQ-024 Back-to-back transfers SHALL sustain one word per cycle with ram_write_en held high continuously.
REQ-025 Address pointer SHALL increment modulo RAM_DEPTH after each LOAD transfer (RAM_DEPTH-1 wraps to 0).
REQ-026 Running sum SHALL be WORD_SIZE-bit, modulo 2^WORD_SIZE, of all payload words.
REQ-027 After the L-th LOAD transfer the state SHALL go to CHECK.
REQ-028 CHECK transfer: err<=1 if in_data != sum (otherwise 0); no RAM write; go FIN.
REQ-029 FIN SHALL last one cycle with done=1, then return to IDLE.
REQ-030 err SHALL hold its value until next accepted start or reset.
REQ-031 ram_write_en SHALL be 0 whenever no LOAD transfer occurred on the previous edge; ram_address/ram_write_data hold last values otherwise.

Reset
REQ-032 rst=1 at an edge SHALL force IDLE, ram_write_en=0, ram_address=0, ram_write_data=0, busy=0, done=0, err=0, pointer=0, sum=0.
REQ-033 rst SHALL take priority over start and any in-flight transfer; a transfer on the reset edge SHALL produce no RAM write.
REQ-034 Outputs SHALL be fully defined from the first cycle after reset with no dependence on initial values.

Verification
REQ-035 base_addr=0, len=4, data 01,02,03,04 back-to-back, checksum 0A -> writes mem[0..3]=01..04 on four consecutive cycles, done pulse, err=0.
REQ-036 base_addr=30, len=4, data AA,BB,CC,DD, checksum 0E -> writes addresses 30,31,0,1; err=0.
REQ-037 len=2, data FF,02, checksum 00 -> err=1 (expected 01), done pulses, err held until next start.
REQ-038 len=0, checksum 00 -> no ram_write_en, done after one transfer, err=0; len=40 -> exactly 32 writes before CHECK.
REQ-039 in_valid toggled 1,0,0,1 during LOAD -> writes only follow valid cycles, addresses contiguous; start pulsed mid-load ignored.
REQ-040 rst asserted after 2 of 4 payload words -> IDLE next cycle, no further writes, busy=0, next start begins fresh at new base_addr.
